data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Handshaked data-memory target for the LEGv8 datapath: the responder end of the
//  load/store port. Accepts one read or write request at a time over valid/ready,
//  services it after a programmable latency, and returns data or an error over a
//  held response channel. Sits between a multi-cycle/stalling core and a word RAM.
// PARAMETERS
//  ADDR_BITS  10  log2 of the number of 64-bit words; byte range is 0 .. 8*2^ADDR_BITS-1
//  LATENCY     2  posedges from request accept to rsp_valid rise; legal range 1..15
// PORTS
//  CLK         in   1   clock; all state updates on posedge
//  resetl      in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_write   in   1   1 = store (STUR), 0 = load (LDUR)
//  req_addr    in   64  byte address
//  req_wdata   in   64  store data
//  rsp_valid   out  1   response present; held until accepted
//  rsp_ready   in   1   requester takes response
//  rsp_rdata   out  64  load data; 0 for stores and errors
//  rsp_err     out  1   misaligned or out-of-range access
//  txn_count   out  32  count of completed responses; wraps 0xFFFFFFFF -> 0
// BEHAVIOUR
//  Reset (resetl low, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, txn_count=0, latency counter=0. RAM contents are not cleared.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: req_ready=1. On posedge with req_valid: capture write/addr/wdata,
//    load cnt=LATENCY, go BUSY. No req_valid: stay.
//   BUSY: req_ready=0. Each posedge: if cnt==1 -> commit access, go RESP; else cnt--.
//    rsp_valid therefore rises exactly LATENCY posedges after the accept edge.
//   RESP: rsp_valid=1, rsp_rdata/rsp_err stable. On posedge with rsp_ready: clear
//    rsp_valid/rsp_rdata/rsp_err, txn_count++, go IDLE. rsp_ready low: hold.
//  Commit (BUSY->RESP edge): word index = addr[ADDR_BITS+2:3].
//   err = (addr[2:0]!=0) | (addr[63:ADDR_BITS+3]!=0). On err: no RAM write,
//   rdata=0. Load: rdata=RAM[index]. Store: RAM[index]<=wdata, rdata=0.
//  Single outstanding transaction; requests arriving in BUSY/RESP are not sampled
//   and must be held by the requester (ready low). Back-to-back throughput: one
//   transaction per LATENCY+2 cycles with rsp_ready held high.
//  Captured request fields are frozen after accept; req_* changes in BUSY ignored.
//  Reset mid-operation: transaction is dropped; a store reset before its commit
//   edge does not modify RAM; a committed store survives reset.
//  Errored responses count in txn_count.
// TESTING
//  1 LATENCY=2: store addr 0x10 data 0xDEAD_BEEF_0000_0001, rsp_ready=1 -> rsp_valid
//    rises 2 edges after accept, rsp_err=0, rsp_rdata=0; load 0x10 -> rdata 0xDEADBEEF00000001
//  2 Load addr 0x0C (misaligned) -> rsp_err=1, rdata=0; load 0x08 unchanged; store
//    to 0x2000 with ADDR_BITS=10 -> rsp_err=1, no RAM write anywhere
//  3 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0,
//    new req_valid ignored; raise rsp_ready -> IDLE next edge, txn_count+1
//  4 Store 0x40 data 0x55, drop resetl during BUSY -> all outputs reset values
//    immediately; load 0x40 after reset -> previous contents, not 0x55
//  5 LATENCY=1, 4 back-to-back loads, rsp_ready=1 -> responses every 3 cycles,
//    txn_count=4; preset txn_count to 0xFFFFFFFF via forcing -> wraps to 0
//  6 Change req_addr/req_wdata during BUSY -> response reflects values captured at accept

Source files
------------

// File: rtl/data_mem_responder.sv
// Handshaked load/store responder in front of a 64-bit word RAM.
// One transaction at a time: accept in IDLE, wait LATENCY edges, then hold the response until it is taken.
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] txn_count
);

  localparam int WORDS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [63:0]            addr_q, addr_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [31:0]            txn_count_q, txn_count_d;
  logic [63:0]            mem [WORDS];
  logic [ADDR_BITS-1:0]   idx_s;
  logic                   err_s;
  logic                   commit_s;

  assign idx_s    = addr_q[ADDR_BITS+2:3];
  assign err_s    = (addr_q[2:0] != 3'd0) | (|addr_q[63:ADDR_BITS+3]);
  assign commit_s = (state_q == S_BUSY) && (cnt_q == 4'd1);

  // Word RAM; deliberately not reset so committed stores survive resetl.
  always_ff @(posedge CLK) begin
    if (commit_s && wr_q && !err_s) begin
      mem[idx_s] <= wdata_q;
    end
  end

  // State and captured-request registers.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      rdata_q     <= 64'd0;
      err_q       <= 1'b0;
      txn_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Next-state logic: request fields are captured only in IDLE, so later req_* changes are ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    txn_count_d = txn_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          err_d   = err_s;
          rdata_d = (!wr_q && !err_s) ? mem[idx_s] : 64'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rdata_d     = 64'd0;
          err_d       = 1'b0;
          txn_count_d = txn_count_q + 32'd1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for functional scenarios, LATENCY=1 instance for throughput.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk;
  logic        resetl;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic [31:0] txn_count;
  logic        req_valid1, req_ready1, req_write1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [63:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [31:0] txn_count1;

  int total;
  int bad;
  int exp_txn;

  data_mem_responder #(.ADDR_BITS(10), .LATENCY(2)) dut0 (
    .CLK(clk), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .txn_count(txn_count)
  );

  data_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .CLK(clk), .resetl(resetl),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .txn_count(txn_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction on dut0; lat is edges from accept to rsp_valid (-1 on timeout).
  task automatic do_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic scramble, output logic [63:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (scramble) begin
      req_write = ~w; req_addr = 64'h20; req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_txn++;
  endtask

  task automatic test_reset;
    resetl = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 64'd0; req_wdata1 = 64'd0; rsp_ready1 = 1'b0;
    exp_txn = 0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", rsp_err); end
    total++; if (txn_count !== 32'd0) begin bad++; $display("FAIL reset_txn got=%0d exp=0", txn_count); end
    resetl = 1'b1;
  endtask

  task automatic test_store_load;
    logic [63:0] rd; logic er; int lat;
    do_txn(1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, 1'b0, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d exp=2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got=%0b exp=0", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
    do_txn(1'b0, 64'h10, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef00000001", rd); end
    total++; if (lat !== 2) begin bad++; $display("FAIL load_latency got=%0d exp=2", lat); end
    total++; if (txn_count !== 32'd2) begin bad++; $display("FAIL txn_after_two got=%0d exp=2", txn_count); end
  endtask

  task automatic test_errors;
    logic [63:0] rd; logic er; int lat;
    do_txn(1'b1, 64'h08, 64'hAAAA_0000_0000_0008, 1'b0, rd, er, lat);
    do_txn(1'b1, 64'h00, 64'hCCCC_0000_0000_0000, 1'b0, rd, er, lat);
    do_txn(1'b0, 64'h0C, 64'd0, 1'b0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL misaligned_err got=%0b exp=1", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL misaligned_rdata got=%h exp=0", rd); end
    do_txn(1'b1, 64'h09, 64'h1234, 1'b0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL misaligned_store_err got=%0b exp=1", er); end
    do_txn(1'b0, 64'h08, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'hAAAA_0000_0000_0008) begin bad++; $display("FAIL word8_intact got=%h exp=aaaa000000000008", rd); end
    do_txn(1'b1, 64'h2000, 64'h5678, 1'b0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL range_err got=%0b exp=1", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL range_rdata got=%h exp=0", rd); end
    do_txn(1'b0, 64'h00, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'hCCCC_0000_0000_0000) begin bad++; $display("FAIL word0_intact got=%h exp=cccc000000000000", rd); end
    total++; if (txn_count !== exp_txn[31:0]) begin bad++; $display("FAIL txn_with_errors got=%0d exp=%0d", txn_count, exp_txn); end
  endtask

  task automatic test_hold;
    logic [63:0] rd; logic er; int lat; int waitc;
    do_txn(1'b1, 64'h48, 64'h7, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waitc = 0;
    while (!rsp_valid && waitc < 50) begin @(negedge clk); waitc++; end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_timeout got=%0b exp=1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h48; req_wdata = 64'h99;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%0b exp=1", i, rsp_valid); end
      total++; if (rsp_rdata !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL hold_rdata cyc=%0d got=%h", i, rsp_rdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready cyc=%0d got=%0b exp=0", i, req_ready); end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_txn++;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%0b exp=0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b exp=1", req_ready); end
    total++; if (rsp_rdata !== 64'd0) begin bad++; $display("FAIL release_rdata got=%h exp=0", rsp_rdata); end
    total++; if (txn_count !== exp_txn[31:0]) begin bad++; $display("FAIL release_txn got=%0d exp=%0d", txn_count, exp_txn); end
    do_txn(1'b0, 64'h48, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'h7) begin bad++; $display("FAIL ignored_store got=%h exp=7", rd); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; logic er; int lat;
    do_txn(1'b1, 64'h40, 64'h1111, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%0b exp=0", req_ready); end
    #2 resetl = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", rsp_valid); end
    total++; if (txn_count !== 32'd0) begin bad++; $display("FAIL midrst_txn got=%0d exp=0", txn_count); end
    repeat (3) @(negedge clk);
    resetl = 1'b1;
    exp_txn = 0;
    do_txn(1'b0, 64'h40, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'h1111) begin bad++; $display("FAIL store_dropped got=%h exp=1111", rd); end
    do_txn(1'b0, 64'h10, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL committed_survives got=%h", rd); end
  endtask

  task automatic test_capture;
    logic [63:0] rd; logic er; int lat;
    do_txn(1'b1, 64'h20, 64'h2020, 1'b0, rd, er, lat);
    do_txn(1'b1, 64'h18, 64'hCAFE, 1'b1, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL capture_err got=%0b exp=0", er); end
    do_txn(1'b0, 64'h18, 64'd0, 1'b0, rd, er, lat);
    total++; if (rd !== 64'hCAFE) begin bad++; $display("FAIL capture_data got=%h exp=cafe", rd); end
    do_txn(1'b0, 64'h20, 64'd0, 1'b1, rd, er, lat);
    total++; if (rd !== 64'h2020) begin bad++; $display("FAIL capture_addr got=%h exp=2020", rd); end
  endtask

  task automatic test_back_to_back;
    int cyc, idx, nresp;
    int tstamp [8];
    logic [63:0] rdv [8];
    logic [31:0] txs [8];
    cyc = 0; idx = 0; nresp = 0;
    rsp_ready1 = 1'b1;
    while (nresp < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid1) begin
        tstamp[nresp] = cyc; rdv[nresp] = rsp_rdata1; txs[nresp] = txn_count1; nresp++;
      end
      if (req_ready1 && idx < 8) begin
        req_valid1 = 1'b1; req_write1 = (idx < 4);
        req_addr1 = 64'h100 + 64'(idx % 4) * 64'd8; req_wdata1 = 64'h1000 + 64'(idx);
        idx++;
      end else if (req_ready1) begin
        req_valid1 = 1'b0;
      end
    end
    req_valid1 = 1'b0;
    @(negedge clk);
    rsp_ready1 = 1'b0;
    total++; if (nresp !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", nresp); end
    for (int k = 0; k < nresp; k++) begin
      if (k > 0) begin
        total++; if (tstamp[k] - tstamp[k-1] !== 3) begin bad++; $display("FAIL b2b_gap k=%0d got=%0d exp=3", k, tstamp[k] - tstamp[k-1]); end
      end
      total++; if (txs[k] !== 32'(k)) begin bad++; $display("FAIL b2b_txn k=%0d got=%0d exp=%0d", k, txs[k], k); end
      if (k >= 4) begin
        total++; if (rdv[k] !== 64'h1000 + 64'(k - 4)) begin bad++; $display("FAIL b2b_rdata k=%0d got=%h", k, rdv[k]); end
      end
    end
    total++; if (txn_count1 !== 32'd8) begin bad++; $display("FAIL b2b_final_txn got=%0d exp=8", txn_count1); end
  endtask

  task automatic test_wrap;
    logic [63:0] rd; logic er; int lat;
    @(negedge clk);
    force dut0.txn_count_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut0.txn_count_d;
    @(negedge clk);
    total++; if (txn_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL preset_txn got=%h exp=ffffffff", txn_count); end
    do_txn(1'b0, 64'h10, 64'd0, 1'b0, rd, er, lat);
    total++; if (txn_count !== 32'd0) begin bad++; $display("FAIL wrap_txn got=%h exp=0", txn_count); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_store_load();
    test_errors();
    test_hold();
    test_reset_mid();
    test_capture();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
